// File: rtl/player_move_ctrl.sv
// Per-player movement and bomb-request controller with wall/bomb/edge/player collision resolution.
// Optional macro TORUS_WRAP_EN: grid edges wrap around instead of blocking the move.
module player_move_ctrl #(
    parameter int unsigned N_PLAYERS   = 2,
    parameter int unsigned GRID_W      = 16,
    parameter int unsigned GRID_H      = 16,
    parameter int unsigned MOVE_PERIOD = 5,
    parameter int unsigned CNT_W       = 3,
    localparam int unsigned XW = $clog2(GRID_W),
    localparam int unsigned YW = $clog2(GRID_H),
    localparam int unsigned CW = $clog2(GRID_W * GRID_H)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PLAYERS-1:0]         in_valid,
    input  logic [3*N_PLAYERS-1:0]       direction,
    input  logic [N_PLAYERS-1:0]         bomb_req,
    input  logic [GRID_W*GRID_H-1:0]     blocked,
    input  logic [CNT_W*N_PLAYERS-1:0]   bomb_num,
    input  logic [CNT_W*N_PLAYERS-1:0]   bomb_max,
    output logic [N_PLAYERS-1:0]         req_ready,
    output logic [XW*N_PLAYERS-1:0]      pos_x,
    output logic [YW*N_PLAYERS-1:0]      pos_y,
    output logic [CW*N_PLAYERS-1:0]      pos_coord,
    output logic [2*N_PLAYERS-1:0]       facing,
    output logic [N_PLAYERS-1:0]         set_bomb,
    output logic [CW*N_PLAYERS-1:0]      bomb_coord
);

    localparam int unsigned KW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

`ifdef TORUS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [2:0] D_UP    = 3'd0;
    localparam logic [2:0] D_DOWN  = 3'd1;
    localparam logic [2:0] D_LEFT  = 3'd2;
    localparam logic [2:0] D_RIGHT = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_COOL
    } state_t;

    state_t               state    [N_PLAYERS];
    logic [KW-1:0]        cool_cnt [N_PLAYERS];
    logic [2:0]           dir_q    [N_PLAYERS];
    logic [XW-1:0]        px       [N_PLAYERS];
    logic [YW-1:0]        py       [N_PLAYERS];
    logic [1:0]           face_q   [N_PLAYERS];
    logic [CW-1:0]        bcoord_q [N_PLAYERS];
    logic [N_PLAYERS-1:0] bomb_q;
    logic [N_PLAYERS-1:0] ready_q;
    logic [N_PLAYERS-1:0] set_q;

    logic [XW-1:0]        tx       [N_PLAYERS];
    logic [YW-1:0]        ty       [N_PLAYERS];
    logic [CW-1:0]        cur_idx  [N_PLAYERS];
    logic [N_PLAYERS-1:0] off;
    logic [N_PLAYERS-1:0] cand;
    logic [N_PLAYERS-1:0] win;
    logic [N_PLAYERS-1:0] bomb_ok;

    function automatic logic [CW-1:0] tile(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return CW'(y) * CW'(GRID_W) + CW'(x);
    endfunction

    function automatic logic [XW-1:0] init_x(input int i);
        return (i == 1 || i == 2) ? XW'(GRID_W - 1) : '0;
    endfunction

    function automatic logic [YW-1:0] init_y(input int i);
        return (i == 1 || i == 3) ? YW'(GRID_H - 1) : '0;
    endfunction

    // Target tile, legality against registered positions, and same-target priority.
    always_comb begin
        off     = '0;
        cand    = '0;
        win     = '0;
        bomb_ok = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            tx[i]      = px[i];
            ty[i]      = py[i];
            cur_idx[i] = tile(px[i], py[i]);
            case (dir_q[i])
                D_UP: begin
                    if (py[i] == '0) begin
                        ty[i]  = YW'(GRID_H - 1);
                        off[i] = !WRAP;
                    end else begin
                        ty[i] = py[i] - YW'(1);
                    end
                end
                D_DOWN: begin
                    if (py[i] == YW'(GRID_H - 1)) begin
                        ty[i]  = '0;
                        off[i] = !WRAP;
                    end else begin
                        ty[i] = py[i] + YW'(1);
                    end
                end
                D_LEFT: begin
                    if (px[i] == '0) begin
                        tx[i]  = XW'(GRID_W - 1);
                        off[i] = !WRAP;
                    end else begin
                        tx[i] = px[i] - XW'(1);
                    end
                end
                D_RIGHT: begin
                    if (px[i] == XW'(GRID_W - 1)) begin
                        tx[i]  = '0;
                        off[i] = !WRAP;
                    end else begin
                        tx[i] = px[i] + XW'(1);
                    end
                end
                default: ;
            endcase
            cand[i] = (state[i] == S_EVAL) && (dir_q[i] < 3'd4) && !off[i]
                      && !blocked[tile(tx[i], ty[i])];
            for (int j = 0; j < N_PLAYERS; j++) begin
                if (j != i && px[j] == tx[i] && py[j] == ty[i]) begin
                    cand[i] = 1'b0;
                end
            end
            bomb_ok[i] = (state[i] == S_EVAL) && bomb_q[i]
                         && (bomb_num[i*CNT_W +: CNT_W] < bomb_max[i*CNT_W +: CNT_W])
                         && !blocked[cur_idx[i]];
        end
        for (int i = 0; i < N_PLAYERS; i++) begin
            win[i] = cand[i];
            for (int j = 0; j < N_PLAYERS; j++) begin
                if (j < i && cand[j] && tx[j] == tx[i] && ty[j] == ty[i]) begin
                    win[i] = 1'b0;
                end
            end
        end
    end

    // Per-player request FSM with registered position, facing and bomb pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                state[i]    <= S_IDLE;
                cool_cnt[i] <= '0;
                dir_q[i]    <= '0;
                px[i]       <= init_x(i);
                py[i]       <= init_y(i);
                face_q[i]   <= '0;
                bcoord_q[i] <= '0;
            end
            bomb_q  <= '0;
            ready_q <= '1;
            set_q   <= '0;
        end else begin
            set_q <= '0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                case (state[i])
                    S_IDLE: begin
                        if (in_valid[i]) begin
                            dir_q[i]   <= direction[3*i +: 3];
                            bomb_q[i]  <= bomb_req[i];
                            state[i]   <= S_EVAL;
                            ready_q[i] <= 1'b0;
                        end
                    end
                    S_EVAL: begin
                        if (win[i]) begin
                            px[i] <= tx[i];
                            py[i] <= ty[i];
                        end
                        if (dir_q[i] < 3'd4) begin
                            face_q[i] <= dir_q[i][1:0];
                        end
                        set_q[i] <= bomb_ok[i];
                        if (bomb_ok[i]) begin
                            bcoord_q[i] <= cur_idx[i];
                        end
                        if (MOVE_PERIOD == 0) begin
                            state[i]   <= S_IDLE;
                            ready_q[i] <= 1'b1;
                        end else begin
                            state[i]    <= S_COOL;
                            cool_cnt[i] <= KW'(MOVE_PERIOD - 1);
                        end
                    end
                    S_COOL: begin
                        if (cool_cnt[i] == '0) begin
                            state[i]   <= S_IDLE;
                            ready_q[i] <= 1'b1;
                        end else begin
                            cool_cnt[i] <= cool_cnt[i] - KW'(1);
                        end
                    end
                    default: begin
                        state[i]   <= S_IDLE;
                        ready_q[i] <= 1'b1;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_out
        assign pos_x[g*XW +: XW]      = px[g];
        assign pos_y[g*YW +: YW]      = py[g];
        assign pos_coord[g*CW +: CW]  = tile(px[g], py[g]);
        assign facing[2*g +: 2]       = face_q[g];
        assign bomb_coord[g*CW +: CW] = bcoord_q[g];
    end

    assign req_ready = ready_q;
    assign set_bomb  = set_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: directed scenarios and randomized traffic compared
// against a timestamp-based behavioural model of moves, cooldowns and bombs.
module tb_player_move_ctrl;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int MP = 5;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int CW = 8;
    localparam int KC = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [3*N-1:0]  direction;
    logic [N-1:0]    bomb_req;
    logic [W*H-1:0]  blocked;
    logic [KC*N-1:0] bomb_num;
    logic [KC*N-1:0] bomb_max;
    logic [N-1:0]    req_ready;
    logic [XW*N-1:0] pos_x;
    logic [YW*N-1:0] pos_y;
    logic [CW*N-1:0] pos_coord;
    logic [2*N-1:0]  facing;
    logic [N-1:0]    set_bomb;
    logic [CW*N-1:0] bomb_coord;

    int vec;
    int errs;

    // model: positions, facing, bomb pulse, and per-player timestamps
    int mx [N], my [N], mf [N], mbc [N], ldir [N];
    int eval_at [N], free_at [N];
    bit msb [N], lbomb [N];
    int ecount;

    always #5 clk = ~clk;

    player_move_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .direction  (direction),
        .bomb_req   (bomb_req),
        .blocked    (blocked),
        .bomb_num   (bomb_num),
        .bomb_max   (bomb_max),
        .req_ready  (req_ready),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_coord  (pos_coord),
        .facing     (facing),
        .set_bomb   (set_bomb),
        .bomb_coord (bomb_coord)
    );

    function automatic void model_reset();
        ecount = 0;
        for (int i = 0; i < N; i++) begin
            mx[i]      = (i == 1 || i == 2) ? W - 1 : 0;
            my[i]      = (i == 1 || i == 3) ? H - 1 : 0;
            mf[i]      = 0;
            msb[i]     = 1'b0;
            mbc[i]     = 0;
            ldir[i]    = 4;
            lbomb[i]   = 1'b0;
            eval_at[i] = -1;
            free_at[i] = 0;
        end
    endfunction

    // One clock edge: resolve requests due now, then accept new strobes from idle players.
    function automatic void model_edge();
        int nx [N];
        int ny [N];
        bit mv [N];
        int dx, dy;
        bit ok;
        ecount++;
        for (int i = 0; i < N; i++) begin
            msb[i] = 1'b0;
            mv[i]  = 1'b0;
            nx[i]  = 0;
            ny[i]  = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (eval_at[i] == ecount) begin
                dx = 0;
                dy = 0;
                case (ldir[i])
                    0: dy = -1;
                    1: dy = 1;
                    2: dx = -1;
                    3: dx = 1;
                    default: ;
                endcase
                if (ldir[i] < 4) mf[i] = ldir[i];
                nx[i] = mx[i] + dx;
                ny[i] = my[i] + dy;
`ifdef TORUS_WRAP_EN
                nx[i] = (nx[i] + W) % W;
                ny[i] = (ny[i] + H) % H;
`endif
                ok = (ldir[i] < 4) && nx[i] >= 0 && nx[i] < W && ny[i] >= 0 && ny[i] < H;
                if (ok && blocked[ny[i]*W + nx[i]]) ok = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (j != i && mx[j] == nx[i] && my[j] == ny[i]) ok = 1'b0;
                    if (j < i && mv[j] && nx[j] == nx[i] && ny[j] == ny[i]) ok = 1'b0;
                end
                mv[i] = ok;
                if (lbomb[i] && bomb_num[i*KC +: KC] < bomb_max[i*KC +: KC]
                    && !blocked[my[i]*W + mx[i]]) begin
                    msb[i] = 1'b1;
                    mbc[i] = my[i]*W + mx[i];
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (mv[i]) begin
                mx[i] = nx[i];
                my[i] = ny[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ecount >= free_at[i] && in_valid[i]) begin
                ldir[i]    = int'(direction[3*i +: 3]);
                lbomb[i]   = bomb_req[i];
                eval_at[i] = ecount + 1;
                free_at[i] = ecount + 2 + MP;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        bomb_req  = '0;
        direction = '0;
        blocked   = '0;
        bomb_num  = '0;
        bomb_max  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic strobe(input logic [N-1:0] v, input int d0, input int d1, input logic [N-1:0] b);
        in_valid  = v;
        direction = {3'(d1), 3'(d0)};
        bomb_req  = b;
        tick();
        in_valid  = '0;
        bomb_req  = '0;
    endtask

    task automatic test_reset();
        int ex, ey;
        do_reset();
        for (int i = 0; i < N; i++) begin
            ex = (i == 1 || i == 2) ? W - 1 : 0;
            ey = (i == 1 || i == 3) ? H - 1 : 0;
            vec++;
            if (pos_x[i*XW +: XW] !== XW'(ex) || pos_y[i*YW +: YW] !== YW'(ey)) begin
                errs++;
                $display("FAIL reset_pos p%0d got (%0d,%0d) want (%0d,%0d)", i,
                         pos_x[i*XW +: XW], pos_y[i*YW +: YW], ex, ey);
            end
            vec++;
            if (pos_coord[i*CW +: CW] !== CW'(ey*W + ex)) begin
                errs++;
                $display("FAIL reset_coord p%0d got %0d want %0d", i, pos_coord[i*CW +: CW], ey*W + ex);
            end
            vec++;
            if (facing[2*i +: 2] !== 2'd0 || set_bomb[i] !== 1'b0 || bomb_coord[i*CW +: CW] !== 8'd0
                || req_ready[i] !== 1'b1) begin
                errs++;
                $display("FAIL reset_misc p%0d got face=%0d set=%b bc=%0d rdy=%b want 0 0 0 1", i,
                         facing[2*i +: 2], set_bomb[i], bomb_coord[i*CW +: CW], req_ready[i]);
            end
        end
    endtask

    task automatic test_move_right();
        strobe(2'b01, 3, 4, 2'b00);
        for (int k = 0; k < 6; k++) begin
            vec++;
            if (req_ready[0] !== 1'b0) begin
                errs++;
                $display("FAIL move_ready_low k=%0d got %b want 0", k, req_ready[0]);
            end
            if (k == 0) begin
                vec++;
                if (pos_x[XW-1:0] !== 4'd0) begin
                    errs++;
                    $display("FAIL move_early x got %0d want 0", pos_x[XW-1:0]);
                end
            end
            if (k == 1) begin
                vec++;
                if (pos_x[XW-1:0] !== 4'd1 || pos_y[YW-1:0] !== 4'd0 || pos_coord[CW-1:0] !== 8'd1
                    || facing[1:0] !== 2'd3) begin
                    errs++;
                    $display("FAIL move_right got (%0d,%0d) c=%0d f=%0d want (1,0) c=1 f=3",
                             pos_x[XW-1:0], pos_y[YW-1:0], pos_coord[CW-1:0], facing[1:0]);
                end
            end
            tick();
        end
        vec++;
        if (req_ready[0] !== 1'b1) begin
            errs++;
            $display("FAIL move_ready_back got %b want 1", req_ready[0]);
        end
    endtask

    task automatic test_blocked_down();
        blocked[17] = 1'b1;
        strobe(2'b01, 1, 4, 2'b01);
        tick();
        vec++;
        if (pos_x[XW-1:0] !== 4'd1 || pos_y[YW-1:0] !== 4'd0 || facing[1:0] !== 2'd1
            || set_bomb[0] !== 1'b0) begin
            errs++;
            $display("FAIL blocked_down got (%0d,%0d) f=%0d set=%b want (1,0) f=1 set=0",
                     pos_x[XW-1:0], pos_y[YW-1:0], facing[1:0], set_bomb[0]);
        end
        repeat (MP) tick();
        blocked = '0;
    endtask

    task automatic test_edge();
        int e0y, e1y;
        do_reset();
`ifdef TORUS_WRAP_EN
        e0y = H - 1;
        e1y = 0;
`else
        e0y = 0;
        e1y = H - 1;
`endif
        strobe(2'b11, 0, 1, 2'b00);
        tick();
        vec++;
        if (pos_x[XW-1:0] !== 4'd0 || pos_y[YW-1:0] !== YW'(e0y) || facing[1:0] !== 2'd0) begin
            errs++;
            $display("FAIL edge_p0 got (%0d,%0d) f=%0d want (0,%0d) f=0",
                     pos_x[XW-1:0], pos_y[YW-1:0], facing[1:0], e0y);
        end
        vec++;
        if (pos_x[2*XW-1:XW] !== 4'd15 || pos_y[2*YW-1:YW] !== YW'(e1y) || facing[3:2] !== 2'd1) begin
            errs++;
            $display("FAIL edge_p1 got (%0d,%0d) f=%0d want (15,%0d) f=1",
                     pos_x[2*XW-1:XW], pos_y[2*YW-1:YW], facing[3:2], e1y);
        end
        repeat (MP) tick();
    endtask

    task automatic test_contention();
        do_reset();
        for (int k = 0; k < 18; k++) begin
            strobe({1'b1, 1'(k < 10)}, (k < 5) ? 3 : 1, (k < 8) ? 2 : 0, 2'b00);
            repeat (MP + 1) tick();
        end
        vec++;
        if (pos_coord[CW-1:0] !== 8'd85 || pos_coord[2*CW-1:CW] !== 8'd87) begin
            errs++;
            $display("FAIL contend_setup got c0=%0d c1=%0d want 85 87", pos_coord[CW-1:0], pos_coord[2*CW-1:CW]);
        end
        strobe(2'b11, 3, 2, 2'b00);
        tick();
        vec++;
        if (pos_x[XW-1:0] !== 4'd6 || pos_y[YW-1:0] !== 4'd5) begin
            errs++;
            $display("FAIL contend_p0 got (%0d,%0d) want (6,5)", pos_x[XW-1:0], pos_y[YW-1:0]);
        end
        vec++;
        if (pos_x[2*XW-1:XW] !== 4'd7 || pos_y[2*YW-1:YW] !== 4'd5 || facing[3:2] !== 2'd2) begin
            errs++;
            $display("FAIL contend_p1 got (%0d,%0d) f=%0d want (7,5) f=2",
                     pos_x[2*XW-1:XW], pos_y[2*YW-1:YW], facing[3:2]);
        end
        repeat (MP) tick();
    endtask

    task automatic test_bomb();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            strobe(2'b01, (k < 3) ? 3 : 1, 4, 2'b00);
            repeat (MP + 1) tick();
        end
        bomb_num = {3'd0, 3'd1};
        bomb_max = {3'd0, 3'd2};
        strobe(2'b01, 3, 4, 2'b01);
        vec++;
        if (set_bomb[0] !== 1'b0) begin
            errs++;
            $display("FAIL bomb_early got %b want 0", set_bomb[0]);
        end
        tick();
        vec++;
        if (set_bomb[0] !== 1'b1 || bomb_coord[CW-1:0] !== 8'd51) begin
            errs++;
            $display("FAIL bomb_pulse got set=%b bc=%0d want set=1 bc=51", set_bomb[0], bomb_coord[CW-1:0]);
        end
        vec++;
        if (pos_x[XW-1:0] !== 4'd4 || pos_y[YW-1:0] !== 4'd3) begin
            errs++;
            $display("FAIL bomb_move got (%0d,%0d) want (4,3)", pos_x[XW-1:0], pos_y[YW-1:0]);
        end
        tick();
        vec++;
        if (set_bomb[0] !== 1'b0) begin
            errs++;
            $display("FAIL bomb_one_cycle got %b want 0", set_bomb[0]);
        end
        repeat (MP - 1) tick();
        bomb_num = {3'd0, 3'd2};
        strobe(2'b01, 3, 4, 2'b01);
        tick();
        vec++;
        if (set_bomb[0] !== 1'b0 || pos_x[XW-1:0] !== 4'd5 || pos_y[YW-1:0] !== 4'd3) begin
            errs++;
            $display("FAIL bomb_full got set=%b (%0d,%0d) want set=0 (5,3)",
                     set_bomb[0], pos_x[XW-1:0], pos_y[YW-1:0]);
        end
        repeat (MP) tick();
        bomb_num = '0;
        bomb_max = '0;
    endtask

    task automatic test_cool_drop();
        strobe(2'b01, 3, 4, 2'b00);
        tick();
        strobe(2'b01, 1, 4, 2'b00);
        repeat (MP) tick();
        vec++;
        if (pos_x[XW-1:0] !== 4'd6 || pos_y[YW-1:0] !== 4'd3 || facing[1:0] !== 2'd3
            || req_ready[0] !== 1'b1) begin
            errs++;
            $display("FAIL cool_drop got (%0d,%0d) f=%0d rdy=%b want (6,3) f=3 rdy=1",
                     pos_x[XW-1:0], pos_y[YW-1:0], facing[1:0], req_ready[0]);
        end
        vec++;
        if (pos_x[XW-1:0] !== XW'(mx[0]) || pos_y[YW-1:0] !== YW'(my[0])) begin
            errs++;
            $display("FAIL cool_model got (%0d,%0d) want (%0d,%0d)", pos_x[XW-1:0], pos_y[YW-1:0], mx[0], my[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (c % 24 == 0) begin
                for (int b = 0; b < W*H; b++) blocked[b] = ($urandom_range(0, 7) == 0);
            end
            in_valid  = 2'($urandom);
            direction = 6'($urandom);
            bomb_req  = 2'($urandom);
            bomb_num  = 6'($urandom);
            bomb_max  = 6'($urandom);
            tick();
            for (int i = 0; i < N; i++) begin
                vec++;
                if (pos_x[i*XW +: XW] !== XW'(mx[i]) || pos_y[i*YW +: YW] !== YW'(my[i])) begin
                    errs++;
                    $display("FAIL rand_pos c=%0d p%0d got (%0d,%0d) want (%0d,%0d)", c, i,
                             pos_x[i*XW +: XW], pos_y[i*YW +: YW], mx[i], my[i]);
                end
                vec++;
                if (pos_coord[i*CW +: CW] !== CW'(my[i]*W + mx[i])) begin
                    errs++;
                    $display("FAIL rand_coord c=%0d p%0d got %0d want %0d", c, i,
                             pos_coord[i*CW +: CW], my[i]*W + mx[i]);
                end
                vec++;
                if (facing[2*i +: 2] !== 2'(mf[i])) begin
                    errs++;
                    $display("FAIL rand_facing c=%0d p%0d got %0d want %0d", c, i, facing[2*i +: 2], mf[i]);
                end
                vec++;
                if (req_ready[i] !== 1'(ecount >= free_at[i] - 1)) begin
                    errs++;
                    $display("FAIL rand_ready c=%0d p%0d got %b want %b", c, i, req_ready[i],
                             ecount >= free_at[i] - 1);
                end
                vec++;
                if (set_bomb[i] !== msb[i]) begin
                    errs++;
                    $display("FAIL rand_setbomb c=%0d p%0d got %b want %b", c, i, set_bomb[i], msb[i]);
                end
                if (msb[i]) begin
                    vec++;
                    if (bomb_coord[i*CW +: CW] !== CW'(mbc[i])) begin
                        errs++;
                        $display("FAIL rand_bcoord c=%0d p%0d got %0d want %0d", c, i,
                                 bomb_coord[i*CW +: CW], mbc[i]);
                    end
                end
            end
        end
        in_valid = '0;
        bomb_req = '0;
    endtask

    task automatic test_reset_mid_eval();
        blocked  = '0;
        bomb_num = '0;
        bomb_max = {3'd7, 3'd7};
        repeat (MP + 2) tick();
        strobe(2'b11, 3, 2, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if (pos_coord[CW-1:0] !== 8'd0 || pos_coord[2*CW-1:CW] !== 8'd255) begin
            errs++;
            $display("FAIL rst_eval_pos got c0=%0d c1=%0d want 0 255", pos_coord[CW-1:0], pos_coord[2*CW-1:CW]);
        end
        vec++;
        if (req_ready !== 2'b11 || facing !== 4'd0 || set_bomb !== 2'b00 || bomb_coord !== 16'd0) begin
            errs++;
            $display("FAIL rst_eval_misc got rdy=%b f=%h set=%b bc=%h want 11 0 00 0",
                     req_ready, facing, set_bomb, bomb_coord);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) tick();
        vec++;
        if (set_bomb !== 2'b00 || req_ready !== 2'b11 || pos_x[XW-1:0] !== XW'(mx[0])
            || pos_y[2*YW-1:YW] !== YW'(my[1])) begin
            errs++;
            $display("FAIL rst_discard got set=%b rdy=%b x0=%0d y1=%0d want 00 11 %0d %0d",
                     set_bomb, req_ready, pos_x[XW-1:0], pos_y[2*YW-1:YW], mx[0], my[1]);
        end
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        test_reset();
        test_move_right();
        test_blocked_down();
        test_edge();
        test_contention();
        test_bomb();
        test_cool_drop();
        test_random();
        test_reset_mid_eval();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
